// File: rtl/btn_pkg.sv
// Shared types and index constants for the push-button front end.
package btn_pkg;

  typedef enum logic [1:0] {
    RELEASED  = 2'd0,
    CHK_PRESS = 2'd1,
    PRESSED   = 2'd2,
    CHK_REL   = 2'd3
  } db_state_t;

  localparam int NUM_BTN = 4;
  localparam int BTN_L   = 3;
  localparam int BTN_U   = 2;
  localparam int BTN_R   = 1;
  localparam int BTN_D   = 0;

endpackage

// File: rtl/button_debouncer.sv
// One button: 2-flop synchroniser, debounce FSM with stability counter,
// registered level and single-cycle press pulse.
module button_debouncer
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  db_state_t        state;
  logic [CNT_W-1:0] cnt;

  // synchroniser stage: btn_raw -> sync_p0 -> sync_p1
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
    end
  end

  // debounce stage: FSM sees only sync_p1
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RELEASED;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      unique case (state)
        RELEASED: begin
          if (sync_p1) begin
            state <= CHK_PRESS;
            cnt   <= '0;
          end
        end
        CHK_PRESS: begin
          if (!sync_p1) begin
            state <= RELEASED;
          end else if (cnt == CNT_TERM) begin
            state <= PRESSED;
            level <= 1'b1;
            press <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        PRESSED: begin
          if (!sync_p1) begin
            state <= CHK_REL;
            cnt   <= '0;
          end
        end
        CHK_REL: begin
          // a release never produces a pulse; a bounce back high resumes PRESSED
          if (sync_p1) begin
            state <= PRESSED;
          end else if (cnt == CNT_TERM) begin
            state <= RELEASED;
            level <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= RELEASED;
      endcase
    end
  end

endmodule

// File: rtl/button_group_ctrl.sv
// Four debounced buttons, each press toggling a latched off bit that
// blanks its 4-LED group of the switch pattern.
module button_group_ctrl
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btnL,
  input  logic        btnU,
  input  logic        btnR,
  input  logic        btnD,
  input  logic [15:0] sw,
  output logic [3:0]  btn_level,
  output logic [3:0]  btn_press,
  output logic [3:0]  group_off,
  output logic [15:0] led
);

  logic [NUM_BTN-1:0] btn_raw;

  assign btn_raw[BTN_L] = btnL;
  assign btn_raw[BTN_U] = btnU;
  assign btn_raw[BTN_R] = btnR;
  assign btn_raw[BTN_D] = btnD;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk    (clk),
      .rst    (rst),
      .btn_raw(btn_raw[i]),
      .level  (btn_level[i]),
      .press  (btn_press[i])
    );
  end

  // toggle stage: one edge after the press pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      group_off <= '0;
    end else begin
      group_off <= group_off ^ btn_press;
    end
  end

  always_comb begin
    led = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      led[4*i +: 4] = sw[4*i +: 4] & {4{~group_off[i]}};
    end
  end

endmodule

// File: tb/tb_button_group_ctrl.sv
// Directed bench for button_group_ctrl with a short debounce window.
module tb_button_group_ctrl;

  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        btnL, btnU, btnR, btnD;
  logic [15:0] sw;
  logic [3:0]  btn_level, btn_press, group_off;
  logic [15:0] led;

  int n_cmp = 0;
  int n_bad = 0;

  button_group_ctrl #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk      (clk),
    .rst      (rst),
    .btnL     (btnL),
    .btnU     (btnU),
    .btnR     (btnR),
    .btnD     (btnD),
    .sw       (sw),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .group_off(group_off),
    .led      (led)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    btnL = 1'b0; btnU = 1'b0; btnR = 1'b0; btnD = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    sw = 16'hFFFF;
    rst  = 1'b1;
    btnL = 1'b0; btnU = 1'b0; btnR = 1'b0; btnD = 1'b0;
    repeat (3) tick();
    n_cmp++; if (btn_level !== 4'b0000) begin n_bad++; $display("FAIL reset_level got=%b exp=%b", btn_level, 4'b0000); end
    n_cmp++; if (btn_press !== 4'b0000) begin n_bad++; $display("FAIL reset_press got=%b exp=%b", btn_press, 4'b0000); end
    n_cmp++; if (group_off !== 4'b0000) begin n_bad++; $display("FAIL reset_group_off got=%b exp=%b", group_off, 4'b0000); end
    n_cmp++; if (led !== 16'hFFFF) begin n_bad++; $display("FAIL reset_led got=%h exp=%h", led, 16'hFFFF); end
    rst = 1'b0;
  endtask

  task automatic test_clean_press();
    logic [3:0] exp_p, exp_l;
    do_reset();
    btnL = 1'b1;
    for (int e = 0; e <= 8; e++) begin
      tick();
      exp_p = (e == 6) ? 4'b1000 : 4'b0000;
      exp_l = (e >= 6) ? 4'b1000 : 4'b0000;
      n_cmp++; if (btn_press !== exp_p) begin n_bad++; $display("FAIL clean_press edge=%0d got=%b exp=%b", e, btn_press, exp_p); end
      n_cmp++; if (btn_level !== exp_l) begin n_bad++; $display("FAIL clean_level edge=%0d got=%b exp=%b", e, btn_level, exp_l); end
    end
    n_cmp++; if (group_off !== 4'b1000) begin n_bad++; $display("FAIL clean_group_off got=%b exp=%b", group_off, 4'b1000); end
    n_cmp++; if (led !== 16'h0FFF) begin n_bad++; $display("FAIL clean_led got=%h exp=%h", led, 16'h0FFF); end
    for (int e = 9; e < 20; e++) begin
      tick();
      n_cmp++; if (btn_press !== 4'b0000) begin n_bad++; $display("FAIL clean_hold_press edge=%0d got=%b exp=%b", e, btn_press, 4'b0000); end
    end
    btnL = 1'b0;
    for (int e = 0; e <= 7; e++) begin
      tick();
      exp_l = (e < 6) ? 4'b1000 : 4'b0000;
      n_cmp++; if (btn_level !== exp_l) begin n_bad++; $display("FAIL release_level edge=%0d got=%b exp=%b", e, btn_level, exp_l); end
      n_cmp++; if (btn_press !== 4'b0000) begin n_bad++; $display("FAIL release_press edge=%0d got=%b exp=%b", e, btn_press, 4'b0000); end
    end
    n_cmp++; if (group_off !== 4'b1000) begin n_bad++; $display("FAIL release_group_off got=%b exp=%b", group_off, 4'b1000); end
  endtask

  task automatic test_bounce();
    logic [3:0] exp_p;
    do_reset();
    for (int e = 0; e <= 11; e++) begin
      btnU = (e == 2) ? 1'b0 : 1'b1;
      tick();
      exp_p = (e == 9) ? 4'b0100 : 4'b0000;
      n_cmp++; if (btn_press !== exp_p) begin n_bad++; $display("FAIL bounce_press edge=%0d got=%b exp=%b", e, btn_press, exp_p); end
    end
    n_cmp++; if (group_off !== 4'b0100) begin n_bad++; $display("FAIL bounce_group_off got=%b exp=%b", group_off, 4'b0100); end
    btnU = 1'b0;
    repeat (8) tick();
  endtask

  task automatic test_toggle_back();
    int pulses;
    pulses = 0;
    do_reset();
    n_cmp++; if (led[3:0] !== 4'hF) begin n_bad++; $display("FAIL toggle_led_init got=%h exp=%h", led[3:0], 4'hF); end
    for (int k = 0; k < 2; k++) begin
      btnD = 1'b1;
      repeat (10) begin tick(); pulses += int'(btn_press[0]); end
      n_cmp++; if (group_off[0] !== (k == 0)) begin n_bad++; $display("FAIL toggle_group_off round=%0d got=%b exp=%b", k, group_off[0], k == 0); end
      n_cmp++; if (led[3:0] !== ((k == 0) ? 4'h0 : 4'hF)) begin n_bad++; $display("FAIL toggle_led round=%0d got=%h exp=%h", k, led[3:0], (k == 0) ? 4'h0 : 4'hF); end
      btnD = 1'b0;
      repeat (10) begin tick(); pulses += int'(btn_press[0]); end
      n_cmp++; if (group_off[0] !== (k == 0)) begin n_bad++; $display("FAIL toggle_after_release round=%0d got=%b exp=%b", k, group_off[0], k == 0); end
    end
    n_cmp++; if (pulses !== 2) begin n_bad++; $display("FAIL toggle_pulse_count got=%0d exp=%0d", pulses, 2); end
  endtask

  task automatic test_simultaneous();
    logic [3:0] exp_p;
    do_reset();
    btnR = 1'b1; btnD = 1'b1;
    for (int e = 0; e <= 7; e++) begin
      tick();
      exp_p = (e == 6) ? 4'b0011 : 4'b0000;
      n_cmp++; if (btn_press !== exp_p) begin n_bad++; $display("FAIL simul_press edge=%0d got=%b exp=%b", e, btn_press, exp_p); end
    end
    n_cmp++; if (group_off !== 4'b0011) begin n_bad++; $display("FAIL simul_group_off got=%b exp=%b", group_off, 4'b0011); end
    n_cmp++; if (led !== 16'hFF00) begin n_bad++; $display("FAIL simul_led got=%h exp=%h", led, 16'hFF00); end
    sw = 16'hA5C3;
    #1;
    n_cmp++; if (led !== 16'hA500) begin n_bad++; $display("FAIL simul_led_sw got=%h exp=%h", led, 16'hA500); end
    btnR = 1'b0; btnD = 1'b0;
    repeat (8) tick();
    sw = 16'hFFFF;
  endtask

  task automatic test_reset_mid_press();
    int pulses;
    do_reset();
    btnL = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    repeat (2) tick();
    n_cmp++; if (btn_level !== 4'b0000) begin n_bad++; $display("FAIL midchk_level got=%b exp=%b", btn_level, 4'b0000); end
    n_cmp++; if (btn_press !== 4'b0000) begin n_bad++; $display("FAIL midchk_press got=%b exp=%b", btn_press, 4'b0000); end
    rst = 1'b0;
    for (int e = 0; e <= 8; e++) begin
      tick();
      n_cmp++; if (btn_press[3] !== (e == 6)) begin n_bad++; $display("FAIL midchk_repress edge=%0d got=%b exp=%b", e, btn_press[3], e == 6); end
    end
    n_cmp++; if (btn_level !== 4'b1000) begin n_bad++; $display("FAIL midchk_pressed_level got=%b exp=%b", btn_level, 4'b1000); end
    rst = 1'b1;
    repeat (2) tick();
    n_cmp++; if (btn_level !== 4'b0000) begin n_bad++; $display("FAIL midpr_level got=%b exp=%b", btn_level, 4'b0000); end
    n_cmp++; if (group_off !== 4'b0000) begin n_bad++; $display("FAIL midpr_group_off got=%b exp=%b", group_off, 4'b0000); end
    n_cmp++; if (led !== 16'hFFFF) begin n_bad++; $display("FAIL midpr_led got=%h exp=%h", led, 16'hFFFF); end
    rst = 1'b0;
    pulses = 0;
    for (int e = 0; e <= 8; e++) begin
      tick();
      pulses += int'(btn_press[3]);
      n_cmp++; if (btn_press[3] !== (e == 6)) begin n_bad++; $display("FAIL midpr_repress edge=%0d got=%b exp=%b", e, btn_press[3], e == 6); end
    end
    n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL midpr_pulse_count got=%0d exp=%0d", pulses, 1); end
    n_cmp++; if (group_off !== 4'b1000) begin n_bad++; $display("FAIL midpr_final_group_off got=%b exp=%b", group_off, 4'b1000); end
    btnL = 1'b0;
    repeat (8) tick();
  endtask

  initial begin
    rst  = 1'b1;
    btnL = 1'b0; btnU = 1'b0; btnR = 1'b0; btnD = 1'b0;
    sw   = 16'hFFFF;
    test_reset();
    test_clean_press();
    test_bounce();
    test_toggle_back();
    test_simultaneous();
    test_reset_mid_press();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
